// File: rtl/apb_decoder.sv
// Purpose : APB 1-to-N address decoder; registers the upstream setup, replays it on one of N regions.
// Latency : hit = 1 upstream wait state + downstream waits; miss = 0 wait states (local error).
// Backpres: upstream PREADY_s follows the selected PREADY_m; a watchdog forces an error on a hung completer.
//
// Ports: PCLK/PRESETn clock and async active-low reset; *_s upstream completer side (from the requester);
//        *_m downstream requester side: one-hot PSEL_m, shared PADDR/PWRITE/PWDATA/PENABLE/PSTRB/PPROT,
//        per-slave PRDATA_m/PREADY_m/PSLVERR_m.
module apb_decoder #(
    parameter int                        NUM_APB_SLAVES = 4,
    parameter int                        APB_ADDR_WIDTH = 32,
    parameter int                        APB_DATA_WIDTH = 32,
    parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h4000_0000,
    parameter int                        REGION_LOG2    = 12,
    parameter int                        TIMEOUT_CYCLES = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic                      PSEL_s,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR_s,
    input  logic                      PWRITE_s,
    input  logic [APB_DATA_WIDTH-1:0] PWDATA_s,
    input  logic                      PENABLE_s,
    input  logic                      PSTRB_s,
    input  logic                      PPROT_s,
    output logic [APB_DATA_WIDTH-1:0] PRDATA_s,
    output logic                      PREADY_s,
    output logic                      PSLVERR_s,
    output logic [NUM_APB_SLAVES-1:0] PSEL_m,
    output logic [APB_ADDR_WIDTH-1:0] PADDR_m,
    output logic                      PWRITE_m,
    output logic [APB_DATA_WIDTH-1:0] PWDATA_m,
    output logic                      PENABLE_m,
    output logic                      PSTRB_m,
    output logic                      PPROT_m,
    input  logic [APB_DATA_WIDTH-1:0] PRDATA_m [NUM_APB_SLAVES],
    input  logic [NUM_APB_SLAVES-1:0] PREADY_m,
    input  logic [NUM_APB_SLAVES-1:0] PSLVERR_m
);

    // A single slave still gets a 1-bit index that is always 0.
    localparam int IDX_W = (NUM_APB_SLAVES > 1) ? $clog2(NUM_APB_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int XW    = APB_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        ERR    = 2'd3
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   wdog_cnt;

    // Window comparison carried one bit wider so BASE + size cannot wrap at the top of the map.
    logic [XW-1:0]      addr_x;
    logic [XW-1:0]      base_x;
    logic [XW-1:0]      top_x;
    logic [XW-1:0]      offset_x;
    logic               dec_hit;
    logic [IDX_W-1:0]   dec_idx;
    logic               unused_offset;

    assign addr_x   = {1'b0, PADDR_s};
    assign base_x   = {1'b0, BASE_ADDR};
    assign top_x    = base_x + (XW'(NUM_APB_SLAVES) << REGION_LOG2);
    assign offset_x = addr_x - base_x;
    assign dec_hit  = (addr_x >= base_x) && (addr_x < top_x);
    assign dec_idx  = offset_x[REGION_LOG2 +: IDX_W];
    assign unused_offset = ^offset_x;

    // Response of the selected completer; everything from the others is ignored.
    logic                      sel_rdy;
    logic                      sel_err;
    logic [APB_DATA_WIDTH-1:0] sel_dat;
    logic                      wdog_expired;

    assign sel_rdy      = PREADY_m[idx_q];
    assign sel_err      = PSLVERR_m[idx_q];
    assign sel_dat      = PRDATA_m[idx_q];
    assign wdog_expired = (TIMEOUT_CYCLES != 0) && (wdog_cnt == CNT_W'(TIMEOUT_CYCLES));

    // Upstream response is combinational. It is gated by PSEL_s so that a requester
    // that abandoned the transfer never sees a stray completion.
    always_comb begin
        PREADY_s  = 1'b0;
        PSLVERR_s = 1'b0;
        PRDATA_s  = '0;
        case (state)
            ACCESS: begin
                if (sel_rdy) begin
                    PREADY_s  = PSEL_s;
                    PSLVERR_s = PSEL_s & sel_err;
                    PRDATA_s  = PSEL_s ? sel_dat : '0;
                end else if (wdog_expired) begin
                    PREADY_s  = PSEL_s;
                    PSLVERR_s = PSEL_s;
                end
            end
            ERR: begin
                PREADY_s  = PSEL_s;
                PSLVERR_s = PSEL_s;
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            idx_q     <= '0;
            wdog_cnt  <= '0;
            PSEL_m    <= '0;
            PENABLE_m <= 1'b0;
            PADDR_m   <= '0;
            PWRITE_m  <= 1'b0;
            PWDATA_m  <= '0;
            PSTRB_m   <= 1'b0;
            PPROT_m   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (PSEL_s && !PENABLE_s) begin
                        PADDR_m  <= PADDR_s;
                        PWRITE_m <= PWRITE_s;
                        PWDATA_m <= PWDATA_s;
                        PSTRB_m  <= PSTRB_s;
                        PPROT_m  <= PPROT_s;
                        idx_q    <= dec_idx;
                        if (dec_hit) begin
                            PSEL_m <= NUM_APB_SLAVES'(1) << dec_idx;
                            state  <= SETUP;
                        end else begin
                            state  <= ERR;
                        end
                    end
                end
                SETUP: begin
                    PENABLE_m <= 1'b1;
                    wdog_cnt  <= '0;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    // A ready seen in the expiry cycle completes normally (handled in the response mux).
                    if (sel_rdy || wdog_expired) begin
                        PSEL_m    <= '0;
                        PENABLE_m <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        wdog_cnt  <= wdog_cnt + 1'b1;
                    end
                end
                ERR: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_decoder.sv
module tb_apb_decoder;

    localparam int          NS   = 4;
    localparam int          AW   = 32;
    localparam int          DW   = 32;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int          TMO  = 16;

    logic          PCLK;
    logic          PRESETn;
    logic          PSEL_s;
    logic [AW-1:0] PADDR_s;
    logic          PWRITE_s;
    logic [DW-1:0] PWDATA_s;
    logic          PENABLE_s;
    logic          PSTRB_s;
    logic          PPROT_s;
    logic [DW-1:0] PRDATA_s;
    logic          PREADY_s;
    logic          PSLVERR_s;
    logic [NS-1:0] PSEL_m;
    logic [AW-1:0] PADDR_m;
    logic          PWRITE_m;
    logic [DW-1:0] PWDATA_m;
    logic          PENABLE_m;
    logic          PSTRB_m;
    logic          PPROT_m;
    logic [DW-1:0] PRDATA_m [NS];
    logic [NS-1:0] PREADY_m;
    logic [NS-1:0] PSLVERR_m;

    apb_decoder #(
        .NUM_APB_SLAVES (NS),
        .APB_ADDR_WIDTH (AW),
        .APB_DATA_WIDTH (DW),
        .BASE_ADDR      (BASE),
        .REGION_LOG2    (12),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .PSEL_s    (PSEL_s),
        .PADDR_s   (PADDR_s),
        .PWRITE_s  (PWRITE_s),
        .PWDATA_s  (PWDATA_s),
        .PENABLE_s (PENABLE_s),
        .PSTRB_s   (PSTRB_s),
        .PPROT_s   (PPROT_s),
        .PRDATA_s  (PRDATA_s),
        .PREADY_s  (PREADY_s),
        .PSLVERR_s (PSLVERR_s),
        .PSEL_m    (PSEL_m),
        .PADDR_m   (PADDR_m),
        .PWRITE_m  (PWRITE_m),
        .PWDATA_m  (PWDATA_m),
        .PENABLE_m (PENABLE_m),
        .PSTRB_m   (PSTRB_m),
        .PPROT_m   (PPROT_m),
        .PRDATA_m  (PRDATA_m),
        .PREADY_m  (PREADY_m),
        .PSLVERR_m (PSLVERR_m)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        int          lat;
        logic [31:0] dat;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Unselected completers shout ready/error/garbage; the decoder must ignore them.
    task automatic drive_noise(input int slv);
        for (int i = 0; i < NS; i++) begin
            PREADY_m[i]  = (i != slv);
            PSLVERR_m[i] = (i != slv);
            PRDATA_m[i]  = 32'hBAD0_0000 | 32'(i);
        end
    endtask

    task automatic go_idle();
        @(posedge PCLK); #1;
        PSEL_s    = 1'b0;
        PENABLE_s = 1'b0;
        PREADY_m  = '0;
        PSLVERR_m = '0;
    endtask

    // One upstream transfer. slv < 0 means no completer should be selected.
    // The completer raises ready after wait_n downstream access cycles.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input int slv, input int wait_n, input logic [31:0] sdata, input logic serr,
                        input logic [3:0] exp_sel, input int exp_lat,
                        input logic [31:0] exp_dat, input logic exp_err);
        exp_t e;
        int   cyc;
        int   acc;
        bit   done;
        logic rdy;
        e.lat = exp_lat; e.dat = exp_dat; e.err = exp_err;
        sb.push_back(e);

        @(posedge PCLK); #1;
        PSEL_s = 1'b1; PENABLE_s = 1'b0; PADDR_s = addr; PWRITE_s = wr;
        PWDATA_s = wdata; PSTRB_s = 1'b1; PPROT_s = wr;
        drive_noise(slv);
        #1;
        chk("c0_psel", 64'(PSEL_m), 64'(0));
        chk("c0_prdy", 64'(PREADY_s), 64'(0));

        cyc = 0; acc = 0; done = 0;
        while (!done && cyc < 40) begin
            @(posedge PCLK); #1;
            cyc++;
            PENABLE_s = 1'b1;
            rdy = 1'b0;
            drive_noise(slv);
            if (slv >= 0) begin
                if (PSEL_m[slv] && PENABLE_m) begin
                    if (acc == wait_n) rdy = 1'b1;
                    else acc++;
                end
                PREADY_m[slv]  = rdy;
                PSLVERR_m[slv] = rdy & serr;
                PRDATA_m[slv]  = rdy ? sdata : 32'h0BAD_0BAD;
            end
            #1;
            if (cyc == 1) begin
                chk("c1_psel",   64'(PSEL_m),    64'(exp_sel));
                chk("c1_pen",    64'(PENABLE_m), 64'(0));
                chk("c1_paddr",  64'(PADDR_m),   64'(addr));
                chk("c1_pwdata", 64'(PWDATA_m),  64'(wdata));
                chk("c1_pwrite", 64'(PWRITE_m),  64'(wr));
            end
            if (cyc == 2 && exp_sel != 0) chk("c2_pen", 64'(PENABLE_m), 64'(1));
            if (PREADY_s) begin
                done = 1;
                if (sb.size() == 0) begin
                    chk("sb_empty", 64'(sb.size()), 64'(1));
                end else begin
                    e = sb.pop_front();
                    chk("lat",    64'(cyc),       64'(e.lat));
                    chk("prdata", 64'(PRDATA_s),  64'(e.dat));
                    chk("pslverr",64'(PSLVERR_s), 64'(e.err));
                end
            end else begin
                chk("wait_prdata", 64'(PRDATA_s),  64'(0));
                chk("wait_perr",   64'(PSLVERR_s), 64'(0));
            end
        end
        chk("completed", 64'(done), 64'(1));
    endtask

    initial begin
        PRESETn = 1'b0; PSEL_s = 1'b0; PADDR_s = '0; PWRITE_s = 1'b0; PWDATA_s = '0;
        PENABLE_s = 1'b0; PSTRB_s = 1'b0; PPROT_s = 1'b0;
        PREADY_m = '0; PSLVERR_m = '0;
        for (int i = 0; i < NS; i++) PRDATA_m[i] = '0;
        repeat (2) @(posedge PCLK);
        #2;
        chk("rst_psel",  64'(PSEL_m),    64'(0));
        chk("rst_pen",   64'(PENABLE_m), 64'(0));
        chk("rst_prdy",  64'(PREADY_s),  64'(0));
        chk("rst_paddr", 64'(PADDR_m),   64'(0));
        @(negedge PCLK);
        PRESETn = 1'b1;

        // Write hit, zero-wait slave 1.
        xfer(BASE + 32'h1004, 1'b1, 32'hA5A5_0001, 1, 0, 32'h0, 1'b0, 4'b0010, 2, 32'h0, 1'b0);
        go_idle();
        // Read hit at the top of region 3 with 3 wait states.
        xfer(BASE + 32'h3FFC, 1'b0, 32'h0, 3, 3, 32'hDEAD_BEEF, 1'b0, 4'b1000, 5, 32'hDEAD_BEEF, 1'b0);
        go_idle();
        // Unmapped: just past the window, just below it, top of the address space.
        xfer(BASE + 32'h4000, 1'b0, 32'h1, -1, 0, 32'h0, 1'b0, 4'b0000, 1, 32'h0, 1'b1);
        go_idle();
        xfer(BASE - 32'h4,    1'b1, 32'h2, -1, 0, 32'h0, 1'b0, 4'b0000, 1, 32'h0, 1'b1);
        go_idle();
        xfer(32'hFFFF_FFFC,   1'b0, 32'h3, -1, 0, 32'h0, 1'b0, 4'b0000, 1, 32'h0, 1'b1);
        go_idle();
        // Hung slave 2: watchdog fires in ACCESS cycle TMO+1 (upstream cycle TMO+2).
        xfer(BASE + 32'h2000, 1'b0, 32'h0, 2, 1000, 32'h0, 1'b0, 4'b0100, TMO + 2, 32'h0, 1'b1);
        go_idle();
        #1 chk("tmo_psel_clr", 64'(PSEL_m), 64'(0));
        // Slave ready in the expiry cycle wins.
        xfer(BASE + 32'h2008, 1'b0, 32'h0, 2, TMO, 32'h1234_5678, 1'b0, 4'b0100, TMO + 2, 32'h1234_5678, 1'b0);
        go_idle();
        // Back-to-back: write slave 0, then read slave 3 that returns an error.
        xfer(BASE + 32'h0010, 1'b1, 32'h0000_00AA, 0, 0, 32'h0, 1'b0, 4'b0001, 2, 32'h0, 1'b0);
        xfer(BASE + 32'h3000, 1'b0, 32'h0, 3, 1, 32'hCAFE_0003, 1'b1, 4'b1000, 3, 32'hCAFE_0003, 1'b1);
        go_idle();

        // Reset during ACCESS to slave 1, with slave ready already presented.
        @(posedge PCLK); #1;
        PSEL_s = 1'b1; PENABLE_s = 1'b0; PADDR_s = BASE + 32'h1000; PWRITE_s = 1'b0;
        drive_noise(1); PREADY_m[1] = 1'b0;
        @(posedge PCLK); #1;
        PENABLE_s = 1'b1;
        @(posedge PCLK); #1;
        PREADY_m[1] = 1'b1; PRDATA_m[1] = 32'h5555_5555;
        #1 chk("pre_rst_rdy", 64'(PREADY_s), 64'(1));
        PRESETn = 1'b0;
        #1;
        chk("arst_psel",  64'(PSEL_m),    64'(0));
        chk("arst_pen",   64'(PENABLE_m), 64'(0));
        chk("arst_prdy",  64'(PREADY_s),  64'(0));
        chk("arst_prdat", 64'(PRDATA_s),  64'(0));
        chk("arst_paddr", 64'(PADDR_m),   64'(0));
        @(posedge PCLK); #1;
        PRESETn = 1'b1; PSEL_s = 1'b0; PENABLE_s = 1'b0; PREADY_m = '0; PSLVERR_m = '0;
        xfer(BASE + 32'h0040, 1'b0, 32'h0, 0, 2, 32'h0000_0A0A, 1'b0, 4'b0001, 4, 32'h0000_0A0A, 1'b0);
        go_idle();

        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
